// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding, starvation
// threshold default and the saturating-increment helper.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } owner_e;

    localparam int unsigned DMEM_MAX_WAIT_DEF = 32'd4;
    localparam int unsigned WAIT_CNT_W        = 32'd3;

    function automatic logic [WAIT_CNT_W-1:0] sat_inc(
        input logic [WAIT_CNT_W-1:0] val,
        input logic [WAIT_CNT_W-1:0] lim
    );
        if (val >= lim) begin
            return lim;
        end else begin
            return val + 3'd1;
        end
    endfunction

endpackage

// File: rtl/dmem_starve_cnt.sv
// Saturating starvation counter for the host port: counts cycles an EXT
// request waits, clears when EXT is granted.
module dmem_starve_cnt
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DMEM_MAX_WAIT_DEF
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  inc_i,
    input  logic                  clr_i,
    output logic [WAIT_CNT_W-1:0] cnt_o
);

    localparam logic [WAIT_CNT_W-1:0] LIM = WAIT_CNT_W'(MAX_WAIT);

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    // Next count: clear on grant takes precedence over a waiting increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 3'd0;
        end else if (inc_i) begin
            cnt_d = sat_inc(cnt_q, LIM);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port SRAM arbiter between the CPU MEM stage and a host port, with
// CPU priority and a bounded starvation guarantee for the host.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W   = 32'd64,
    parameter int unsigned ADDR_W   = 32'd64,
    parameter int unsigned MAX_WAIT = DMEM_MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic              cpu_ren,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_wen,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ren,
    output logic              mem_wen,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIM = WAIT_CNT_W'(MAX_WAIT);

    owner_e                owner_q;
    owner_e                owner_d;
    logic                  ext_ack_q;
    logic [DATA_W-1:0]     cpu_rdata_q;
    logic [DATA_W-1:0]     ext_rdata_q;
    logic                  cpu_req_s;
    logic                  ext_req_s;
    logic                  grant_cpu_s;
    logic                  grant_ext_s;
    logic [WAIT_CNT_W-1:0] wait_cnt_s;

    // Request qualification and grant; the host cannot be regranted in its own ack cycle.
    always_comb begin
        cpu_req_s = enable & (cpu_ren | cpu_wen);
        ext_req_s = ext_req & (owner_q != OWN_EXT);
        if (cpu_req_s && ext_req_s) begin
            grant_ext_s = (wait_cnt_s == WAIT_LIM);
            grant_cpu_s = (wait_cnt_s != WAIT_LIM);
        end else begin
            grant_cpu_s = cpu_req_s;
            grant_ext_s = ext_req_s;
        end
        if (grant_cpu_s) begin
            owner_d = OWN_CPU;
        end else if (grant_ext_s) begin
            owner_d = OWN_EXT;
        end else begin
            owner_d = OWN_NONE;
        end
        cpu_stall = cpu_req_s & ~grant_cpu_s;
    end

    // SRAM port steering from the granted requester; idle port is all-zero.
    always_comb begin
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        case (owner_d)
            OWN_CPU: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_ren   = cpu_ren;
                mem_wen   = cpu_wen;
            end
            OWN_EXT: begin
                mem_addr  = ext_addr;
                mem_wdata = ext_wdata;
                mem_ren   = ~ext_wen;
                mem_wen   = ext_wen;
            end
            default: begin
                mem_addr  = {ADDR_W{1'b0}};
                mem_wdata = {DATA_W{1'b0}};
                mem_ren   = 1'b0;
                mem_wen   = 1'b0;
            end
        endcase
    end

    dmem_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc_i  (ext_req_s & ~grant_ext_s),
        .clr_i  (grant_ext_s),
        .cnt_o  (wait_cnt_s)
    );

    // Owner, ack and read-data hold registers; reset drops any in-flight response.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            owner_q     <= OWN_NONE;
            ext_ack_q   <= 1'b0;
            cpu_rdata_q <= {DATA_W{1'b0}};
            ext_rdata_q <= {DATA_W{1'b0}};
        end else begin
            owner_q   <= owner_d;
            ext_ack_q <= grant_ext_s;
            if (owner_q == OWN_CPU) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (owner_q == OWN_EXT) begin
                ext_rdata_q <= mem_rdata;
            end
        end
    end

    assign ext_ack   = ext_ack_q;
    assign cpu_rdata = (owner_q == OWN_CPU) ? mem_rdata : cpu_rdata_q;
    assign ext_rdata = (owner_q == OWN_EXT) ? mem_rdata : ext_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, reset
// sequence, then randomized traffic against a rule-level reference model.
module tb_dmem_arbiter;

    localparam int DW   = 64;
    localparam int AW   = 64;
    localparam int MAXW = 4;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          enable, cpu_ren, cpu_wen, ext_req, ext_wen;
    logic [AW-1:0] cpu_addr, ext_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, ext_wdata, cpu_rdata, ext_rdata, mem_wdata, mem_rdata;
    logic          cpu_stall, ext_ack, mem_ren, mem_wen;

    logic          tb_we;
    logic [5:0]    tb_waddr;
    logic [63:0]   tb_wdata;
    logic [63:0]   sram [64];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .arst_n(arst_n), .enable(enable),
        .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_wen(ext_wen), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_ack(ext_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_rdata(mem_rdata)
    );

    // SRAM model: synchronous write, read data registered one cycle after mem_ren.
    always @(posedge clk) begin
        if (tb_we) sram[tb_waddr] <= tb_wdata;
        else if (mem_wen) sram[mem_addr[5:0]] <= mem_wdata;
        if (mem_ren) mem_rdata <= sram[mem_addr[5:0]];
    end

    function automatic logic [63:0] init_val(input int i);
        if (i == 16) return 64'hDEAD;
        else if (i == 32) return 64'hBEEF;
        else return 64'hA5A5_0000 + 64'(i);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        en, cren, cwen;
        logic [7:0]  caddr;
        logic [15:0] cwd;
        logic        ereq, ewen;
        logic [7:0]  eaddr;
        logic        mren, mwen;
        logic [7:0]  maddr;
        logic [15:0] mwd;
        logic        stall, ack, chk_erd;
        logic [15:0] erd;
        logic        chk_crd;
        logic [15:0] crd;
    } vec_t;

    vec_t vecs [11];

    // reference model state
    int          m_owner, m_wait, winner, op;
    logic [63:0] m_mem [64];
    logic [63:0] m_srd, m_erd, m_crd;
    logic        h_busy, h_wen;
    logic [5:0]  h_addr;
    logic [63:0] h_wd;

    initial begin
        //           en   cren cwen caddr  cwd       ereq ewen eaddr  | mren mwen maddr  mwd       stall ack  cerd erd        ccrd crd
        vecs[0]  = '{1'b0,1'b0,1'b0,8'h00,16'h0000,1'b1,1'b0,8'h10, 1'b1,1'b0,8'h10,16'h0000,1'b0,1'b0,1'b0,16'h0000,1'b1,16'h0000};
        vecs[1]  = '{1'b0,1'b0,1'b0,8'h00,16'h0000,1'b1,1'b0,8'h10, 1'b0,1'b0,8'h00,16'h0000,1'b0,1'b1,1'b1,16'hDEAD,1'b0,16'h0000};
        vecs[2]  = '{1'b0,1'b0,1'b0,8'h00,16'h0000,1'b1,1'b0,8'h10, 1'b1,1'b0,8'h10,16'h0000,1'b0,1'b0,1'b1,16'hDEAD,1'b0,16'h0000};
        vecs[3]  = '{1'b1,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,8'h10, 1'b0,1'b0,8'h00,16'h0000,1'b0,1'b1,1'b1,16'hDEAD,1'b0,16'h0000};
        vecs[4]  = '{1'b1,1'b0,1'b1,8'h08,16'h0055,1'b1,1'b0,8'h20, 1'b0,1'b1,8'h08,16'h0055,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000};
        vecs[5]  = '{1'b1,1'b1,1'b0,8'h08,16'h0000,1'b1,1'b0,8'h20, 1'b1,1'b0,8'h08,16'h0000,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000};
        vecs[6]  = '{1'b1,1'b1,1'b0,8'h10,16'h0000,1'b1,1'b0,8'h20, 1'b1,1'b0,8'h10,16'h0000,1'b0,1'b0,1'b0,16'h0000,1'b1,16'h0055};
        vecs[7]  = '{1'b1,1'b1,1'b0,8'h08,16'h0000,1'b1,1'b0,8'h20, 1'b1,1'b0,8'h08,16'h0000,1'b0,1'b0,1'b0,16'h0000,1'b1,16'hDEAD};
        vecs[8]  = '{1'b1,1'b1,1'b0,8'h08,16'h0000,1'b1,1'b0,8'h20, 1'b1,1'b0,8'h20,16'h0000,1'b1,1'b0,1'b0,16'h0000,1'b1,16'h0055};
        vecs[9]  = '{1'b1,1'b1,1'b0,8'h08,16'h0000,1'b1,1'b0,8'h20, 1'b1,1'b0,8'h08,16'h0000,1'b0,1'b1,1'b1,16'hBEEF,1'b1,16'h0055};
        vecs[10] = '{1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b1,16'hBEEF,1'b1,16'h0055};

        arst_n = 1'b0; enable = 1'b0; cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b0; ext_wen = 1'b0; ext_addr = '0; ext_wdata = '0;
        tb_we = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tb_waddr = 6'(i);
            tb_wdata = init_val(i);
            @(posedge clk); #1;
        end
        tb_we = 1'b0;

        // reset values while held in reset
        chk("por ext_ack", {63'd0, ext_ack}, 64'd0);
        chk("por cpu_rdata", cpu_rdata, 64'd0);
        chk("por ext_rdata", ext_rdata, 64'd0);
        chk("por cpu_stall", {63'd0, cpu_stall}, 64'd0);
        chk("por mem_ren", {63'd0, mem_ren}, 64'd0);
        arst_n = 1'b1;

        // directed vector table
        for (int i = 0; i < 11; i++) begin
            enable = vecs[i].en; cpu_ren = vecs[i].cren; cpu_wen = vecs[i].cwen;
            cpu_addr = 64'(vecs[i].caddr); cpu_wdata = 64'(vecs[i].cwd);
            ext_req = vecs[i].ereq; ext_wen = vecs[i].ewen; ext_addr = 64'(vecs[i].eaddr); ext_wdata = 64'd0;
            @(negedge clk);
            chk($sformatf("row%0d mem_ren", i), {63'd0, mem_ren}, {63'd0, vecs[i].mren});
            chk($sformatf("row%0d mem_wen", i), {63'd0, mem_wen}, {63'd0, vecs[i].mwen});
            chk($sformatf("row%0d mem_addr", i), mem_addr, 64'(vecs[i].maddr));
            chk($sformatf("row%0d mem_wdata", i), mem_wdata, 64'(vecs[i].mwd));
            chk($sformatf("row%0d cpu_stall", i), {63'd0, cpu_stall}, {63'd0, vecs[i].stall});
            chk($sformatf("row%0d ext_ack", i), {63'd0, ext_ack}, {63'd0, vecs[i].ack});
            if (vecs[i].chk_erd) chk($sformatf("row%0d ext_rdata", i), ext_rdata, 64'(vecs[i].erd));
            if (vecs[i].chk_crd) chk($sformatf("row%0d cpu_rdata", i), cpu_rdata, 64'(vecs[i].crd));
            @(posedge clk); #1;
        end

        // reset while the host access is in flight
        enable = 1'b0; cpu_ren = 1'b0; cpu_wen = 1'b0;
        ext_req = 1'b1; ext_wen = 1'b0; ext_addr = 64'h20;
        @(negedge clk);
        chk("rst grant mem_ren", {63'd0, mem_ren}, 64'd1);
        @(posedge clk); #1;
        ext_req = 1'b0;
        arst_n = 1'b0;
        #2;
        chk("rst ext_ack", {63'd0, ext_ack}, 64'd0);
        chk("rst ext_rdata", ext_rdata, 64'd0);
        chk("rst cpu_rdata", cpu_rdata, 64'd0);
        chk("rst mem_ren", {63'd0, mem_ren}, 64'd0);
        #1;
        arst_n = 1'b1;
        ext_req = 1'b1; ext_addr = 64'h10;
        @(negedge clk);
        chk("post-rst ext_ack", {63'd0, ext_ack}, 64'd0);
        chk("post-rst mem_ren", {63'd0, mem_ren}, 64'd1);
        chk("post-rst mem_addr", mem_addr, 64'h10);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post-rst ack", {63'd0, ext_ack}, 64'd1);
        chk("post-rst ext_rdata", ext_rdata, 64'hDEAD);
        chk("post-rst no regrant", {63'd0, mem_ren}, 64'd0);
        @(posedge clk); #1;
        ext_req = 1'b0;
        @(negedge clk);
        chk("post-rst ack drop", {63'd0, ext_ack}, 64'd0);
        @(posedge clk); #1;

        // randomized traffic against the reference model
        for (int i = 0; i < 64; i++) m_mem[i] = init_val(i);
        m_mem[8] = 64'h55;
        m_owner = 0; m_wait = 0;
        m_srd = 64'hDEAD; m_erd = 64'hDEAD; m_crd = 64'd0;
        h_busy = 1'b0; h_wen = 1'b0; h_addr = 6'd0; h_wd = 64'd0;
        for (int c = 0; c < 400; c++) begin
            logic cpu_wants, ext_wants, ack_now;
            logic e_ren, e_wen, e_stall;
            logic [63:0] e_addr, e_wd, e_erd, e_crd;
            if (!h_busy && $urandom_range(2, 0) == 0) begin
                h_busy = 1'b1;
                h_wen  = 1'($urandom_range(1, 0));
                h_addr = 6'($urandom_range(63, 0));
                h_wd   = {$urandom, $urandom};
            end
            ext_req = h_busy; ext_wen = h_busy & h_wen; ext_addr = 64'(h_addr); ext_wdata = h_wd;
            op = $urandom_range(3, 0);
            cpu_ren = (op == 1) || (op == 3); cpu_wen = (op == 2);
            cpu_addr = 64'($urandom_range(63, 0)); cpu_wdata = {$urandom, $urandom};
            enable = ($urandom_range(7, 0) != 0);
            @(negedge clk);

            cpu_wants = enable && (cpu_ren || cpu_wen);
            ext_wants = ext_req && (m_owner != 2);
            if (cpu_wants && ext_wants) winner = (m_wait == MAXW) ? 2 : 1;
            else if (cpu_wants) winner = 1;
            else if (ext_wants) winner = 2;
            else winner = 0;
            e_ren = 1'b0; e_wen = 1'b0; e_addr = 64'd0; e_wd = 64'd0;
            if (winner == 1) begin
                e_ren = cpu_ren; e_wen = cpu_wen; e_addr = cpu_addr; e_wd = cpu_wdata;
            end else if (winner == 2) begin
                e_ren = !ext_wen; e_wen = ext_wen; e_addr = ext_addr; e_wd = ext_wdata;
            end
            e_stall = cpu_wants && (winner != 1);
            ack_now = (m_owner == 2);
            e_erd = ack_now ? m_srd : m_erd;
            e_crd = (m_owner == 1) ? m_srd : m_crd;

            chk($sformatf("rnd%0d mem_ren", c), {63'd0, mem_ren}, {63'd0, e_ren});
            chk($sformatf("rnd%0d mem_wen", c), {63'd0, mem_wen}, {63'd0, e_wen});
            chk($sformatf("rnd%0d mem_addr", c), mem_addr, e_addr);
            chk($sformatf("rnd%0d mem_wdata", c), mem_wdata, e_wd);
            chk($sformatf("rnd%0d cpu_stall", c), {63'd0, cpu_stall}, {63'd0, e_stall});
            chk($sformatf("rnd%0d ext_ack", c), {63'd0, ext_ack}, {63'd0, ack_now});
            chk($sformatf("rnd%0d ext_rdata", c), ext_rdata, e_erd);
            chk($sformatf("rnd%0d cpu_rdata", c), cpu_rdata, e_crd);

            m_erd = e_erd; m_crd = e_crd;
            if (e_wen) m_mem[e_addr[5:0]] = e_wd;
            if (e_ren) m_srd = m_mem[e_addr[5:0]];
            if (winner == 2) m_wait = 0;
            else if (ext_wants) m_wait = (m_wait >= MAXW) ? MAXW : m_wait + 1;
            m_owner = winner;
            if (ack_now) h_busy = 1'b0;
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
